player_motion_ctrl: RTL and testbench

Parametrised player-movement controller for the top-down map view. It samples the directional buttons at a fixed update rate and proposes a new player position clamped to the map bounds. The proposal goes through a request/acknowledge handshake to an external collision checker, and the position is committed only when the move is accepted. The block sits between the button inputs and the map/raycast renderers, and its pos_x/pos_y feed every drawing block.

---
 rtl/player_motion_ctrl_if.sv | 42 ++++
 rtl/player_motion_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_motion_ctrl_if.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl_if
// Request/acknowledge bundle between the movement controller and the external
// collision checker.
//
// Handshake: the master raises chk_req together with a proposed top-left
// position (chk_x, chk_y) and holds all three stable until the slave answers
// with a one-cycle chk_ack pulse; chk_ok is only meaningful in that cycle.
// The master drops chk_req on the clock edge that observes chk_ack.
//
// Signals:
//   chk_req  master -> slave   collision check request
//   chk_x    master -> slave   proposed x (POS_W bits)
//   chk_y    master -> slave   proposed y (POS_W bits)
//   chk_ack  slave  -> master  check done, 1-cycle pulse
//   chk_ok   slave  -> master  proposal legal, valid while chk_ack=1
// -----------------------------------------------------------------------------
interface player_motion_ctrl_if #(
    parameter int POS_W = 10
);
    logic             chk_req;
    logic [POS_W-1:0] chk_x;
    logic [POS_W-1:0] chk_y;
    logic             chk_ack;
    logic             chk_ok;

    modport master (
        output chk_req,
        output chk_x,
        output chk_y,
        input  chk_ack,
        input  chk_ok
    );

    modport slave (
        input  chk_req,
        input  chk_x,
        input  chk_y,
        output chk_ack,
        output chk_ok
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl
// Player movement controller for the top-down map view. Directional buttons are
// sampled once per update tick (CLK_HZ/UPDATE_HZ clocks), the resulting step is
// clamped to the map bounds and offered to an external collision checker; the
// committed position only changes when the checker accepts the proposal.
//
// Optional feature (macro WALL_SLIDE_EN): when a diagonal move is rejected, the
// X-only and then the Y-only component are retried, each with a full handshake
// and its own timeout window. Without the macro a rejected move is dropped.
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-low reset
//   enable         1 = movement allowed, 0 = ticks ignored while idle
//   btn_left/right/up/down  active-high buttons, asynchronous to clk
//   chk            collision-check handshake (player_motion_ctrl_if.master)
//   pos_x, pos_y   committed top-left position
//   moved          1-cycle pulse when the position changes
//   busy           1 whenever the FSM is not idle
//   timeout_flag   sticky, set when the checker fails to answer in TIMEOUT cycles
//   overrun_cnt    saturating count of ticks dropped while busy
//   state_dbg      current FSM state encoding, for debug/assertions
// -----------------------------------------------------------------------------
module player_motion_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int UPDATE_HZ = 100,
    parameter int POS_W     = 10,
    parameter int STEP      = 1,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 620,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 460,
    parameter int RESET_X   = 310,
    parameter int RESET_Y   = 220,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_up,
    input  logic                btn_down,
    player_motion_ctrl_if.master chk,
    output logic [POS_W-1:0]    pos_x,
    output logic [POS_W-1:0]    pos_y,
    output logic                moved,
    output logic                busy,
    output logic                timeout_flag,
    output logic [7:0]          overrun_cnt,
    output logic [2:0]          state_dbg
);

    localparam int DIV   = CLK_HZ / UPDATE_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SAMPLE   = 3'd1,
        S_PROPOSE  = 3'd2,
        S_WAIT_CHK = 3'd3,
        S_COMMIT   = 3'd4,
        S_REJECT   = 3'd5
    } state_t;

    // ---------------- update tick ----------------
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    // tick is high during the last count, so the FSM acts on the wrap edge
    assign tick = (tick_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // ---------------- button synchroniser ----------------
    // bit order: {left, right, up, down}
    logic [3:0] btn_meta;
    logic [3:0] btn_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= {btn_left, btn_right, btn_up, btn_down};
            btn_sync <= btn_meta;
        end
    end

    // opposing buttons cancel; y grows downwards
    logic x_inc_s, x_dec_s, y_inc_s, y_dec_s;
    assign x_inc_s = btn_sync[2] & ~btn_sync[3];
    assign x_dec_s = btn_sync[3] & ~btn_sync[2];
    assign y_inc_s = btn_sync[0] & ~btn_sync[1];
    assign y_dec_s = btn_sync[1] & ~btn_sync[0];

    // ---------------- state and datapath registers ----------------
    state_t           state, state_n;
    logic [3:0]       dir, dir_n;          // {x_inc, x_dec, y_inc, y_dec}
    logic [TO_W-1:0]  wait_cnt, wait_n;
    logic             req_q, req_n;
    logic [POS_W-1:0] cx_q, cx_n, cy_q, cy_n;
    logic [POS_W-1:0] pos_x_q, pos_x_n, pos_y_q, pos_y_n;
    logic             moved_q, moved_n;
    logic             timeout_q, timeout_n;
    logic [7:0]       overrun_q, overrun_n;
`ifdef WALL_SLIDE_EN
    logic [1:0]       attempt, attempt_n;  // 0 diagonal, 1 X-only, 2 Y-only
`endif

    // One step along an axis, saturated to [lo, hi]. Done in 32-bit signed
    // arithmetic so a step below zero saturates instead of wrapping.
    function automatic logic [POS_W-1:0] step_axis(
        input logic [POS_W-1:0] p,
        input logic             inc,
        input logic             dec,
        input int               lo,
        input int               hi
    );
        int v;
        v = int'(p);
        if (inc)      v = v + STEP;
        else if (dec) v = v - STEP;
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return v[POS_W-1:0];
    endfunction

    logic [POS_W-1:0] nx, ny;
    assign nx = step_axis(pos_x_q, dir[3], dir[2], X_MIN, X_MAX);
    assign ny = step_axis(pos_y_q, dir[1], dir[0], Y_MIN, Y_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            dir       <= '0;
            wait_cnt  <= '0;
            req_q     <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
            pos_x_q   <= POS_W'(RESET_X);
            pos_y_q   <= POS_W'(RESET_Y);
            moved_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= '0;
`ifdef WALL_SLIDE_EN
            attempt   <= '0;
`endif
        end else begin
            state     <= state_n;
            dir       <= dir_n;
            wait_cnt  <= wait_n;
            req_q     <= req_n;
            cx_q      <= cx_n;
            cy_q      <= cy_n;
            pos_x_q   <= pos_x_n;
            pos_y_q   <= pos_y_n;
            moved_q   <= moved_n;
            timeout_q <= timeout_n;
            overrun_q <= overrun_n;
`ifdef WALL_SLIDE_EN
            attempt   <= attempt_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        dir_n     = dir;
        wait_n    = wait_cnt;
        req_n     = req_q;
        cx_n      = cx_q;
        cy_n      = cy_q;
        pos_x_n   = pos_x_q;
        pos_y_n   = pos_y_q;
        moved_n   = 1'b0;
        timeout_n = timeout_q;
        overrun_n = overrun_q;
`ifdef WALL_SLIDE_EN
        attempt_n = attempt;
`endif

        // ticks are never queued: one arriving mid-update is just counted
        if (tick && (state != S_IDLE) && (overrun_q != 8'hFF))
            overrun_n = overrun_q + 8'd1;

        case (state)
            S_IDLE: begin
                if (tick && enable) state_n = S_SAMPLE;
            end

            S_SAMPLE: begin
                dir_n = {x_inc_s, x_dec_s, y_inc_s, y_dec_s};
`ifdef WALL_SLIDE_EN
                attempt_n = 2'd0;
`endif
                if (x_inc_s | x_dec_s | y_inc_s | y_dec_s) state_n = S_PROPOSE;
                else                                         state_n = S_IDLE;
            end

            S_PROPOSE: begin
                // pinned against a wall: nothing to ask the checker
                if ((nx == pos_x_q) && (ny == pos_y_q)) begin
                    state_n = S_IDLE;
                end else begin
                    cx_n    = nx;
                    cy_n    = ny;
                    req_n   = 1'b1;
                    wait_n  = '0;
                    state_n = S_WAIT_CHK;
                end
            end

            S_WAIT_CHK: begin
                if (chk.chk_ack) begin
                    req_n   = 1'b0;
                    state_n = chk.chk_ok ? S_COMMIT : S_REJECT;
                end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                    req_n     = 1'b0;
                    timeout_n = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end

            S_COMMIT: begin
                pos_x_n = cx_q;
                pos_y_n = cy_q;
                moved_n = 1'b1;
                state_n = S_IDLE;
            end

            S_REJECT: begin
`ifdef WALL_SLIDE_EN
                // slide along the wall: try the X component, then the Y one
                if ((attempt == 2'd0) && (nx != pos_x_q) && (ny != pos_y_q)) begin
                    cx_n      = nx;
                    cy_n      = pos_y_q;
                    attempt_n = 2'd1;
                    req_n     = 1'b1;
                    wait_n    = '0;
                    state_n   = S_WAIT_CHK;
                end else if (attempt == 2'd1) begin
                    cx_n      = pos_x_q;
                    cy_n      = ny;
                    attempt_n = 2'd2;
                    req_n     = 1'b1;
                    wait_n    = '0;
                    state_n   = S_WAIT_CHK;
                end else begin
                    state_n = S_IDLE;
                end
`else
                state_n = S_IDLE;
`endif
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign chk.chk_req  = req_q;
    assign chk.chk_x    = cx_q;
    assign chk.chk_y    = cy_q;
    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign moved        = moved_q;
    assign busy         = (state != S_IDLE);
    assign timeout_flag = timeout_q;
    assign overrun_cnt  = overrun_q;
    assign state_dbg    = state;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_motion_ctrl
// Self-checking bench for player_motion_ctrl with DIV = 10 (CLK_HZ=1000,
// UPDATE_HZ=100). A behavioural collision checker answers requests after a
// configurable delay; a monitor counts requests and moves and scoreboards the
// committed positions. Build with +define+WALL_SLIDE_EN to check the
// wall-slide variant; the expectations follow the macro.
// -----------------------------------------------------------------------------
module tb_player_motion_ctrl;

    localparam int POS_W = 10;
    localparam int STEP  = 1;
    localparam int XMAX  = 620;
    localparam int YMAX  = 460;

    // button vector order: {left, right, up, down}
    localparam logic [3:0] B_L = 4'b1000;
    localparam logic [3:0] B_R = 4'b0100;
    localparam logic [3:0] B_U = 4'b0010;
    localparam logic [3:0] B_D = 4'b0001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             enable;
    logic             btn_left, btn_right, btn_up, btn_down;
    logic [POS_W-1:0] pos_x, pos_y;
    logic             moved, busy, timeout_flag;
    logic [7:0]       overrun_cnt;
    logic [2:0]       state_dbg;

    player_motion_ctrl_if #(.POS_W(POS_W)) bus ();

    player_motion_ctrl #(
        .CLK_HZ(1000),
        .UPDATE_HZ(100),
        .POS_W(POS_W),
        .STEP(STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .chk(bus),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .moved(moved),
        .busy(busy),
        .timeout_flag(timeout_flag),
        .overrun_cnt(overrun_cnt),
        .state_dbg(state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- collision checker model ----------------
    int         ck_delay      = 2;
    bit         ck_never      = 1'b0;
    bit         ck_reject_all = 1'b0;
    logic [2*POS_W-1:0] rej_list[$];

    function automatic bit in_rej(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y);
        foreach (rej_list[i]) if (rej_list[i] == {x, y}) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        bus.chk_ack = 1'b0;
        bus.chk_ok  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst && bus.chk_req) begin
                if (ck_never) begin
                    while (bus.chk_req) begin @(posedge clk); #1; end
                end else begin
                    repeat (ck_delay) @(posedge clk);
                    #1;
                    bus.chk_ok  = !(ck_reject_all || in_rej(bus.chk_x, bus.chk_y));
                    bus.chk_ack = 1'b1;
                    @(posedge clk); #1;
                    bus.chk_ack = 1'b0;
                    bus.chk_ok  = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [2*POS_W-1:0] exp_q[$];
    bit   sb_on        = 1'b0;
    int   moved_cnt    = 0;
    int   req_rise_cnt = 0;
    int   req_hi_cnt   = 0;
    int   first_cx     = 0;
    int   first_cy     = 0;
    logic req_prev     = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.chk_req) req_hi_cnt++;
            if (bus.chk_req && !req_prev) begin
                if (req_rise_cnt == 0) begin
                    first_cx = int'(bus.chk_x);
                    first_cy = int'(bus.chk_y);
                end
                req_rise_cnt++;
            end
            if (moved) begin
                moved_cnt++;
                if (sb_on) begin
                    if (exp_q.size() == 0) check("sb_unexpected_move", int'({pos_x, pos_y}), -1);
                    else check("sb_move_pos", int'({pos_x, pos_y}), int'(exp_q.pop_front()));
                end
            end
        end
        req_prev = bus.chk_req;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] b);
        btn_left  = b[3];
        btn_right = b[2];
        btn_up    = b[1];
        btn_down  = b[0];
    endtask

    task automatic clear_mon();
        moved_cnt    = 0;
        req_rise_cnt = 0;
        req_hi_cnt   = 0;
        first_cx     = 0;
        first_cy     = 0;
    endtask

    // leaves the bench 1 time unit after the clock edge of reset release;
    // ticks then fall on edges 10, 20, 30, ...
    task automatic apply_reset();
        rst    = 1'b0;
        enable = 1'b1;
        set_btn(4'b0000);
        wait_cycles(3);
        rst = 1'b1;
        clear_mon();
    endtask

    // called just after a tick edge: exactly n ticks see buttons b, and the
    // bench returns just after a later tick edge with all handshakes finished
    task automatic hold(input logic [3:0] b, input int n);
        set_btn(b);
        wait_cycles(10 * n);
        set_btn(4'b0000);
        wait_cycles(10);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] btn;
        logic       en;
        logic       rej;
        int         ex, ey, emoves, ereqs, ecx, ecy;
        string      name;
    } vec_t;

    vec_t vecs[13];

    int   mx, my, exp_moves, exp_reqs;

    initial begin
        vecs[0]  = '{4'b0000, 1'b1, 1'b0, 310, 220, 0, 0,   0,   0, "none"};
        vecs[1]  = '{4'b0100, 1'b1, 1'b0, 311, 220, 1, 1, 311, 220, "right"};
        vecs[2]  = '{4'b1000, 1'b1, 1'b0, 309, 220, 1, 1, 309, 220, "left"};
        vecs[3]  = '{4'b0010, 1'b1, 1'b0, 310, 219, 1, 1, 310, 219, "up"};
        vecs[4]  = '{4'b0001, 1'b1, 1'b0, 310, 221, 1, 1, 310, 221, "down"};
        vecs[5]  = '{4'b1100, 1'b1, 1'b0, 310, 220, 0, 0,   0,   0, "left_right"};
        vecs[6]  = '{4'b0011, 1'b1, 1'b0, 310, 220, 0, 0,   0,   0, "up_down"};
        vecs[7]  = '{4'b1010, 1'b1, 1'b0, 309, 219, 1, 1, 309, 219, "left_up"};
        vecs[8]  = '{4'b0101, 1'b1, 1'b0, 311, 221, 1, 1, 311, 221, "right_down"};
        vecs[9]  = '{4'b1111, 1'b1, 1'b0, 310, 220, 0, 0,   0,   0, "all_four"};
        vecs[10] = '{4'b0100, 1'b0, 1'b0, 310, 220, 0, 0,   0,   0, "right_disabled"};
        vecs[11] = '{4'b0100, 1'b1, 1'b1, 310, 220, 0, 1, 311, 220, "right_rejected"};
        vecs[12] = '{4'b1110, 1'b1, 1'b0, 310, 219, 1, 1, 310, 219, "lr_up"};

        set_btn(4'b0000);
        enable = 1'b1;

        // ---- reset values and first tick position ----
        apply_reset();
        check("rst_pos_x", int'(pos_x), 310);
        check("rst_pos_y", int'(pos_y), 220);
        check("rst_chk_req", int'(bus.chk_req), 0);
        check("rst_chk_x", int'(bus.chk_x), 0);
        check("rst_chk_y", int'(bus.chk_y), 0);
        check("rst_moved", int'(moved), 0);
        check("rst_timeout", int'(timeout_flag), 0);
        check("rst_overrun", int'(overrun_cnt), 0);
        check("rst_busy", int'(busy), 0);
        wait_cycles(9);
        check("tick_not_before_10", int'(busy), 0);
        wait_cycles(1);
        check("tick_at_10", int'(busy), 1);
        wait_cycles(1);
        check("idle_after_empty_sample", int'(busy), 0);

        // ---- table of single-update vectors ----
        for (int i = 0; i < 13; i++) begin
            apply_reset();
            set_btn(vecs[i].btn);
            enable        = vecs[i].en;
            ck_reject_all = vecs[i].rej;
            wait_cycles(10);
            set_btn(4'b0000);
            enable = 1'b1;
            wait_cycles(10);
            ck_reject_all = 1'b0;
            check({vecs[i].name, "_pos_x"}, int'(pos_x), vecs[i].ex);
            check({vecs[i].name, "_pos_y"}, int'(pos_y), vecs[i].ey);
            check({vecs[i].name, "_moves"}, moved_cnt, vecs[i].emoves);
            check({vecs[i].name, "_reqs"}, req_rise_cnt, vecs[i].ereqs);
            if (vecs[i].ereqs > 0) begin
                check({vecs[i].name, "_chk_x"}, first_cx, vecs[i].ecx);
                check({vecs[i].name, "_chk_y"}, first_cy, vecs[i].ecy);
            end
        end

        // ---- hold right for three ticks ----
        apply_reset();
        hold(B_R, 3);
        check("right3_pos_x", int'(pos_x), 313);
        check("right3_pos_y", int'(pos_y), 220);
        check("right3_moves", moved_cnt, 3);
        check("right3_overrun", int'(overrun_cnt), 0);

        // ---- sweep into the top-left and bottom-right corners ----
        apply_reset();
        hold(B_L | B_U, 315);
        check("tl_pos_x", int'(pos_x), 0);
        check("tl_pos_y", int'(pos_y), 0);
        check("tl_moves", moved_cnt, 310);
        clear_mon();
        hold(B_L | B_U, 3);
        check("tl_clamp_reqs", req_rise_cnt, 0);
        check("tl_clamp_pos_x", int'(pos_x), 0);
        check("tl_clamp_pos_y", int'(pos_y), 0);
        clear_mon();
        hold(B_R | B_D, 625);
        check("br_pos_x", int'(pos_x), XMAX);
        check("br_pos_y", int'(pos_y), YMAX);
        check("br_moves", moved_cnt, 620);
        clear_mon();
        hold(B_R, 3);
        hold(B_D, 2);
        check("br_clamp_reqs", req_rise_cnt, 0);
        check("br_clamp_pos_x", int'(pos_x), XMAX);
        check("br_clamp_pos_y", int'(pos_y), YMAX);
        check("sweep_overrun", int'(overrun_cnt), 0);

        // ---- randomized updates from the corner against a reference model ----
        mx = XMAX; my = YMAX; exp_moves = 0; exp_reqs = 0;
        clear_mon();
        sb_on = 1'b1;
        for (int it = 0; it < 60; it++) begin
            logic [3:0] b;
            bit en, rj, diag;
            int dx, dy, nx, ny;
            b  = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 7) != 0);
            rj = ($urandom_range(0, 3) == 0);
            dx = int'(b[2]) - int'(b[3]);
            dy = int'(b[0]) - int'(b[1]);
            nx = mx + dx * STEP;
            ny = my + dy * STEP;
            nx = (nx < 0) ? 0 : ((nx > XMAX) ? XMAX : nx);
            ny = (ny < 0) ? 0 : ((ny > YMAX) ? YMAX : ny);
            if (en && (nx != mx || ny != my)) begin
                diag = (nx != mx) && (ny != my);
                if (!rj) begin
                    mx = nx; my = ny;
                    exp_q.push_back({POS_W'(nx), POS_W'(ny)});
                    exp_moves++;
                    exp_reqs++;
                end else begin
`ifdef WALL_SLIDE_EN
                    exp_reqs += diag ? 3 : 1;
`else
                    exp_reqs += 1;
`endif
                end
            end
            set_btn(b);
            enable        = en;
            ck_reject_all = rj;
            wait_cycles(10);
            set_btn(4'b0000);
            enable = 1'b1;
            wait_cycles(20);
            ck_reject_all = 1'b0;
            check("rand_pos_x", int'(pos_x), mx);
            check("rand_pos_y", int'(pos_y), my);
        end
        sb_on = 1'b0;
        check("rand_moves", moved_cnt, exp_moves);
        check("rand_reqs", req_rise_cnt, exp_reqs);
        check("rand_sb_empty", exp_q.size(), 0);

        // ---- checker never answers: timeout ----
        apply_reset();
        ck_never = 1'b1;
        set_btn(B_R);
        wait_cycles(10);
        set_btn(4'b0000);
        wait_cycles(290);
        ck_never = 1'b0;
        check("to_req_high_cycles", req_hi_cnt, 255);
        check("to_flag", int'(timeout_flag), 1);
        check("to_pos_x", int'(pos_x), 310);
        check("to_moves", moved_cnt, 0);
        check("to_overrun", int'(overrun_cnt), 25);
        hold(B_R, 1);
        check("to_recover_pos_x", int'(pos_x), 311);
        check("to_flag_sticky", int'(timeout_flag), 1);

        // ---- slow checker: ticks dropped while waiting ----
        apply_reset();
        ck_delay = 25;
        set_btn(B_R);
        wait_cycles(10);
        set_btn(4'b0000);
        wait_cycles(40);
        ck_delay = 2;
        check("slow_overrun", int'(overrun_cnt), 2);
        check("slow_pos_x", int'(pos_x), 311);
        check("slow_moves", moved_cnt, 1);
        check("slow_reqs", req_rise_cnt, 1);

        // ---- reset in the middle of a handshake ----
        apply_reset();
        ck_never = 1'b1;
        set_btn(B_R);
        wait_cycles(10);
        set_btn(4'b0000);
        wait_cycles(5);
        check("abort_req_before", int'(bus.chk_req), 1);
        #2 rst = 1'b0;
        #1;
        check("abort_req_async_drop", int'(bus.chk_req), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_pos_x", int'(pos_x), 310);
        ck_never = 1'b0;

        // ---- diagonal rejected at (100,100) ----
        apply_reset();
        hold(B_L | B_U, 120);
        hold(B_L, 90);
        check("ws_start_x", int'(pos_x), 100);
        check("ws_start_y", int'(pos_y), 100);
        clear_mon();
        rej_list.push_back({POS_W'(101), POS_W'(101)});
        hold(B_R | B_D, 1);
`ifdef WALL_SLIDE_EN
        check("ws_x_pos_x", int'(pos_x), 101);
        check("ws_x_pos_y", int'(pos_y), 100);
        check("ws_x_moves", moved_cnt, 1);
        check("ws_x_reqs", req_rise_cnt, 2);
`else
        check("ws_x_pos_x", int'(pos_x), 100);
        check("ws_x_pos_y", int'(pos_y), 100);
        check("ws_x_moves", moved_cnt, 0);
        check("ws_x_reqs", req_rise_cnt, 1);
`endif
        // from the current position, reject the diagonal and the X-only slide
        clear_mon();
        rej_list.delete();
        rej_list.push_back({POS_W'(int'(pos_x) + 1), POS_W'(int'(pos_y) + 1)});
        rej_list.push_back({POS_W'(int'(pos_x) + 1), pos_y});
`ifdef WALL_SLIDE_EN
        hold(B_R | B_D, 1);
        check("ws_y_pos_x", int'(pos_x), 101);
        check("ws_y_pos_y", int'(pos_y), 101);
        check("ws_y_moves", moved_cnt, 1);
        check("ws_y_reqs", req_rise_cnt, 3);
`else
        hold(B_R | B_D, 1);
        check("ws_y_pos_x", int'(pos_x), 100);
        check("ws_y_pos_y", int'(pos_y), 100);
        check("ws_y_moves", moved_cnt, 0);
        check("ws_y_reqs", req_rise_cnt, 1);
`endif
        rej_list.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
